// File: rtl/msrv32_dmem_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package msrv32_dmem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic {
    CORE = 1'b0,
    AUX  = 1'b1
  } req_id_e;

  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/msrv32_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 = core, bit 1 = aux; ties go to the side not granted last.
module msrv32_rr_arb2
  import msrv32_dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       gnt_en,
  output logic [1:0] gnt
);

  req_id_e last_q;

  always_comb begin
    gnt = 2'b00;
    if (gnt_en) begin
      if (req == 2'b11) gnt = (last_q == AUX) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // Resetting to AUX lets the core win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           last_q <= AUX;
    else if (gnt_en && (req != 2'b00))    last_q <= gnt[1] ? AUX : CORE;
  end

endmodule

// File: rtl/msrv32_dmem_arbiter.sv
// Shares the single data-memory port between the core load/store path and an auxiliary
// requester, one registered transaction at a time with an acknowledge timeout.
module msrv32_dmem_arbiter
  import msrv32_dmem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 5
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,

  input  logic             core_req_in,
  input  logic             core_we_in,
  input  logic [WIDTH-1:0] core_addr_in,
  input  logic [WIDTH-1:0] core_wdata_in,
  input  logic [3:0]       core_mask_in,
  output logic             core_stall_out,
  output logic             core_done_out,
  output logic [WIDTH-1:0] core_rdata_out,
  output logic             core_err_out,

  input  logic             aux_req_in,
  input  logic             aux_we_in,
  input  logic [WIDTH-1:0] aux_addr_in,
  input  logic [WIDTH-1:0] aux_wdata_in,
  input  logic [3:0]       aux_mask_in,
  output logic             aux_done_out,
  output logic [WIDTH-1:0] aux_rdata_out,
  output logic             aux_err_out,

  output logic [WIDTH-1:0] ms_riscv32_mp_dmaddr_out,
  output logic [WIDTH-1:0] ms_riscv32_mp_dmdata_out,
  output logic [3:0]       ms_riscv32_mp_dmwr_mask_out,
  output logic             ms_riscv32_mp_dmwr_req_out,
  output logic             ms_riscv32_mp_dmrd_req_out,
  input  logic [WIDTH-1:0] ms_riscv32_mp_dmdata_in,
  input  logic             ms_riscv32_mp_dmack_in
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  req_id_e          owner_q;

  logic [1:0]       req_eff;
  logic [1:0]       gnt;
  logic             gnt_en;
  logic             timeout_hit;
  logic             sel_aux;
  logic             sel_we;
  logic [WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic [3:0]       sel_mask;

  // A requester is still holding its request in the cycle its done pulses; mask it
  // so the finished access is not issued a second time.
  assign req_eff = {aux_req_in & ~aux_done_out, core_req_in & ~core_done_out};
  assign gnt_en  = (state_q == IDLE);

  assign sel_aux   = gnt[1];
  assign sel_we    = sel_aux ? aux_we_in    : core_we_in;
  assign sel_addr  = sel_aux ? aux_addr_in  : core_addr_in;
  assign sel_wdata = sel_aux ? aux_wdata_in : core_wdata_in;
  assign sel_mask  = sel_aux ? aux_mask_in  : core_mask_in;

  assign timeout_hit    = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign core_stall_out = core_req_in & ~core_done_out;

  msrv32_rr_arb2 u_arb (
    .clk    (ms_riscv32_mp_clk_in),
    .rst_n  (ms_riscv32_mp_rst_in),
    .req    (req_eff),
    .gnt_en (gnt_en),
    .gnt    (gnt)
  );

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) state_q <= IDLE;
    else                       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt != 2'b00) state_d = BUSY;
      BUSY:    if (ms_riscv32_mp_dmack_in || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      cnt_q                       <= '0;
      owner_q                     <= CORE;
      ms_riscv32_mp_dmaddr_out    <= '0;
      ms_riscv32_mp_dmdata_out    <= '0;
      ms_riscv32_mp_dmwr_mask_out <= '0;
      ms_riscv32_mp_dmwr_req_out  <= 1'b0;
      ms_riscv32_mp_dmrd_req_out  <= 1'b0;
      core_done_out               <= 1'b0;
      core_err_out                <= 1'b0;
      core_rdata_out              <= '0;
      aux_done_out                <= 1'b0;
      aux_err_out                 <= 1'b0;
      aux_rdata_out               <= '0;
    end else begin
      core_done_out <= 1'b0;
      core_err_out  <= 1'b0;
      aux_done_out  <= 1'b0;
      aux_err_out   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt != 2'b00) begin
            owner_q                     <= sel_aux ? AUX : CORE;
            ms_riscv32_mp_dmaddr_out    <= sel_addr & {{(WIDTH-2){1'b1}}, 2'b00};
            ms_riscv32_mp_dmdata_out    <= sel_wdata;
            ms_riscv32_mp_dmwr_mask_out <= sel_mask;
            ms_riscv32_mp_dmwr_req_out  <= sel_we;
            ms_riscv32_mp_dmrd_req_out  <= ~sel_we;
            cnt_q                       <= '0;
          end
        end
        BUSY: begin
          // Acknowledge takes priority over a timeout in the same cycle.
          if (ms_riscv32_mp_dmack_in) begin
            ms_riscv32_mp_dmwr_req_out <= 1'b0;
            ms_riscv32_mp_dmrd_req_out <= 1'b0;
            if (owner_q == AUX) begin
              aux_done_out <= 1'b1;
              if (ms_riscv32_mp_dmrd_req_out) aux_rdata_out <= ms_riscv32_mp_dmdata_in;
            end else begin
              core_done_out <= 1'b1;
              if (ms_riscv32_mp_dmrd_req_out) core_rdata_out <= ms_riscv32_mp_dmdata_in;
            end
          end else if (timeout_hit) begin
            ms_riscv32_mp_dmwr_req_out <= 1'b0;
            ms_riscv32_mp_dmrd_req_out <= 1'b0;
            if (owner_q == AUX) begin
              aux_done_out <= 1'b1;
              aux_err_out  <= 1'b1;
            end else begin
              core_done_out <= 1'b1;
              core_err_out  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_dmem_arbiter.sv
// Bench for msrv32_dmem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_msrv32_dmem_arbiter;

  localparam int TO = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;

  logic        core_req = 1'b0, core_we = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [3:0]  core_mask = '0;
  logic        core_stall, core_done, core_err;
  logic [31:0] core_rdata;

  logic        aux_req = 1'b0, aux_we = 1'b0;
  logic [31:0] aux_addr = '0, aux_wdata = '0;
  logic [3:0]  aux_mask = '0;
  logic        aux_done, aux_err;
  logic [31:0] aux_rdata;

  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_mask;
  logic        dm_wr, dm_rd;
  logic [31:0] dm_rdata_in = '0;
  logic        dm_ack = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  msrv32_dmem_arbiter dut (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_in        (rst_n),
    .core_req_in                 (core_req),
    .core_we_in                  (core_we),
    .core_addr_in                (core_addr),
    .core_wdata_in               (core_wdata),
    .core_mask_in                (core_mask),
    .core_stall_out              (core_stall),
    .core_done_out               (core_done),
    .core_rdata_out              (core_rdata),
    .core_err_out                (core_err),
    .aux_req_in                  (aux_req),
    .aux_we_in                   (aux_we),
    .aux_addr_in                 (aux_addr),
    .aux_wdata_in                (aux_wdata),
    .aux_mask_in                 (aux_mask),
    .aux_done_out                (aux_done),
    .aux_rdata_out               (aux_rdata),
    .aux_err_out                 (aux_err),
    .ms_riscv32_mp_dmaddr_out    (dm_addr),
    .ms_riscv32_mp_dmdata_out    (dm_wdata),
    .ms_riscv32_mp_dmwr_mask_out (dm_mask),
    .ms_riscv32_mp_dmwr_req_out  (dm_wr),
    .ms_riscv32_mp_dmrd_req_out  (dm_rd),
    .ms_riscv32_mp_dmdata_in     (dm_rdata_in),
    .ms_riscv32_mp_dmack_in      (dm_ack)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    check(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // Transaction-level model: one outstanding access, its age in strobe cycles,
  // and the expected values of every registered output.
  logic        m_busy, m_owner_aux, m_last_aux, m_is_wr;
  logic        m_cdone, m_adone, m_cerr, m_aerr;
  logic [31:0] m_addr, m_data, m_crd, m_ard;
  logic [3:0]  m_mask;
  int          m_age;

  task automatic model_reset();
    m_busy = 1'b0; m_owner_aux = 1'b0; m_last_aux = 1'b1; m_is_wr = 1'b0;
    m_cdone = 1'b0; m_adone = 1'b0; m_cerr = 1'b0; m_aerr = 1'b0;
    m_addr = '0; m_data = '0; m_crd = '0; m_ard = '0; m_mask = '0; m_age = 0;
  endtask

  task automatic finish_txn(input logic with_err, input logic [31:0] rd);
    m_busy = 1'b0;
    if (m_owner_aux) begin
      m_adone = 1'b1; m_aerr = with_err;
      if (!with_err && !m_is_wr) m_ard = rd;
    end else begin
      m_cdone = 1'b1; m_cerr = with_err;
      if (!with_err && !m_is_wr) m_crd = rd;
    end
  endtask

  task automatic model_step();
    logic want_c, want_a, take_aux;
    want_c = core_req && !m_cdone;
    want_a = aux_req && !m_adone;
    m_cdone = 1'b0; m_adone = 1'b0; m_cerr = 1'b0; m_aerr = 1'b0;
    if (!m_busy) begin
      if (want_c || want_a) begin
        take_aux    = (want_c && want_a) ? !m_last_aux : want_a;
        m_last_aux  = take_aux;
        m_owner_aux = take_aux;
        m_busy      = 1'b1;
        m_age       = 0;
        m_is_wr     = take_aux ? aux_we : core_we;
        m_addr      = (take_aux ? aux_addr : core_addr) & 32'hFFFF_FFFC;
        m_data      = take_aux ? aux_wdata : core_wdata;
        m_mask      = take_aux ? aux_mask : core_mask;
      end
    end else if (dm_ack) begin
      finish_txn(1'b0, dm_rdata_in);
    end else if (m_age + 1 == TO) begin
      finish_txn(1'b1, '0);
    end else begin
      m_age++;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("dmaddr", dm_addr, m_addr);
        check("dmdata", dm_wdata, m_data);
        check("dmmask", {28'd0, dm_mask}, {28'd0, m_mask});
        check1("wr_req", dm_wr, m_busy && m_is_wr);
        check1("rd_req", dm_rd, m_busy && !m_is_wr);
        check1("core_done", core_done, m_cdone);
        check1("aux_done", aux_done, m_adone);
        check1("core_err", core_err, m_cerr);
        check1("aux_err", aux_err, m_aerr);
        check("core_rdata", core_rdata, m_crd);
        check("aux_rdata", aux_rdata, m_ard);
        check1("core_stall", core_stall, core_req & ~m_cdone);
        check1("done_exclusive", core_done & aux_done, 1'b0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // Called in the first strobe cycle; returns in the done cycle.
  task automatic serve(input int lat, input logic [31:0] rd);
    repeat (lat) nxt();
    dm_rdata_in = rd;
    dm_ack      = 1'b1;
    nxt();
    dm_ack      = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    nxt();
  endtask

  initial begin
    int rd_cycles;
    int sc;

    // Reset values
    nxt(); nxt();
    check1("rst_rd", dm_rd, 1'b0);
    check1("rst_wr", dm_wr, 1'b0);
    check("rst_addr", dm_addr, 32'h0);
    check1("rst_core_done", core_done, 1'b0);
    rst_n = 1'b1;
    nxt();
    check("rst_core_rdata", core_rdata, 32'h0);
    check("rst_aux_rdata", aux_rdata, 32'h0);

    // Core load, ack two cycles after the strobe rises
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h104; core_mask = 4'hF;
    rd_cycles = 0;
    nxt(); if (dm_rd) rd_cycles++;
    check("load_addr", dm_addr, 32'h104);
    check1("load_stall", core_stall, 1'b1);
    nxt(); if (dm_rd) rd_cycles++;
    nxt(); if (dm_rd) rd_cycles++;
    dm_ack = 1'b1; dm_rdata_in = 32'hDEADBEEF;
    nxt(); dm_ack = 1'b0;
    check("load_rd_cycles", rd_cycles, 3);
    check1("load_done", core_done, 1'b1);
    check("load_rdata", core_rdata, 32'hDEADBEEF);
    check1("load_stall_done", core_stall, 1'b0);
    core_req = 1'b0;
    nxt();

    // Round robin: from reset core wins the tie, then aux
    pulse_reset();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h1000;
    aux_req  = 1'b1; aux_we  = 1'b0; aux_addr  = 32'h2000;
    nxt();
    check("arb_first_core", dm_addr, 32'h1000);
    serve(0, 32'h1000_AAAA);
    check1("arb_core_done", core_done, 1'b1);
    core_req = 1'b0;
    nxt();
    check("arb_then_aux", dm_addr, 32'h2000);
    serve(0, 32'h2000_AAAA);
    check("arb_aux_rdata", aux_rdata, 32'h2000_AAAA);
    aux_req = 1'b0;
    nxt();
    core_req = 1'b1; core_addr = 32'h1100;
    nxt();
    serve(0, 32'h1100_0000);
    core_req = 1'b0;
    nxt();
    core_req = 1'b1; core_addr = 32'h1200;
    aux_req  = 1'b1; aux_addr  = 32'h2200;
    nxt();
    check("arb_tie_aux", dm_addr, 32'h2200);
    serve(0, 32'h2222_0000);
    aux_req = 1'b0;
    nxt();
    check("arb_tie_core", dm_addr, 32'h1200);
    serve(0, 32'h1200_0000);
    core_req = 1'b0;
    nxt();

    // Aux store to an unaligned address while the core waits
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h203; aux_wdata = 32'hAB000000; aux_mask = 4'b1000;
    nxt();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h300;
    check("st_addr", dm_addr, 32'h200);
    check("st_mask", {28'd0, dm_mask}, 32'h8);
    check("st_data", dm_wdata, 32'hAB000000);
    nxt();
    check1("st_wr_c2", dm_wr, 1'b1);
    check1("st_stall_c2", core_stall, 1'b1);
    serve(1, 32'h0);
    check1("st_aux_done", aux_done, 1'b1);
    check1("st_wr_drop", dm_wr, 1'b0);
    check1("st_stall_done", core_stall, 1'b1);
    aux_req = 1'b0;
    nxt();
    check("st_core_next", dm_addr, 32'h300);
    serve(0, 32'h12345678);
    check("st_core_rdata", core_rdata, 32'h12345678);
    core_req = 1'b0;
    nxt();

    // Timeout on an aux load, then a normal access
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h400;
    nxt();
    sc = 0;
    for (int i = 0; i < TO + 4 && !aux_done; i++) begin
      if (dm_rd) sc++;
      nxt();
    end
    check("to_strobe_cycles", sc, TO);
    check1("to_done", aux_done, 1'b1);
    check1("to_err", aux_err, 1'b1);
    check1("to_rd_drop", dm_rd, 1'b0);
    check("to_rdata_kept", aux_rdata, 32'h2222_0000);
    aux_req = 1'b0;
    nxt();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h500;
    nxt();
    serve(1, 32'h0BADF00D);
    check1("after_to_done", core_done, 1'b1);
    check1("after_to_err", core_err, 1'b0);
    check("after_to_rdata", core_rdata, 32'h0BADF00D);
    core_req = 1'b0;
    nxt();

    // Ack in the last cycle before the timeout
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h600;
    nxt();
    serve(TO - 1, 32'hCAFE0600);
    check1("late_ack_done", aux_done, 1'b1);
    check1("late_ack_err", aux_err, 1'b0);
    check("late_ack_rdata", aux_rdata, 32'hCAFE0600);
    aux_req = 1'b0;
    nxt();

    // Store with an empty mask is still issued
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h800; core_wdata = 32'h5A5A5A5A; core_mask = 4'b0000;
    nxt();
    check1("mask0_wr", dm_wr, 1'b1);
    check("mask0_mask", {28'd0, dm_mask}, 32'h0);
    serve(0, 32'h0);
    check1("mask0_done", core_done, 1'b1);
    core_req = 1'b0;
    nxt();

    // Reset in the middle of a core load
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h700;
    nxt();
    check1("mid_rst_rd_before", dm_rd, 1'b1);
    nxt();
    rst_n = 1'b0;
    #1;
    check1("mid_rst_rd_async", dm_rd, 1'b0);
    check1("mid_rst_wr_async", dm_wr, 1'b0);
    nxt();
    check1("mid_rst_no_done", core_done, 1'b0);
    check("mid_rst_addr", dm_addr, 32'h0);
    rst_n = 1'b1;
    nxt();
    check1("mid_rst_regrant", dm_rd, 1'b1);
    check("mid_rst_regrant_addr", dm_addr, 32'h700);
    serve(0, 32'h77);
    check("mid_rst_rdata", core_rdata, 32'h77);
    core_req = 1'b0;
    nxt();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (core_req && m_cdone) core_req = 1'b0;
      else if (core_req && m_busy && !m_owner_aux && $urandom_range(0, 15) == 0) core_req = 1'b0;
      else if (!core_req && $urandom_range(0, 3) == 0) begin
        core_req   = 1'b1;
        core_we    = 1'($urandom_range(0, 1));
        core_addr  = $urandom;
        core_wdata = $urandom;
        core_mask  = 4'($urandom_range(0, 15));
      end
      if (aux_req && m_adone) aux_req = 1'b0;
      else if (aux_req && m_busy && m_owner_aux && $urandom_range(0, 15) == 0) aux_req = 1'b0;
      else if (!aux_req && $urandom_range(0, 3) == 0) begin
        aux_req   = 1'b1;
        aux_we    = 1'($urandom_range(0, 1));
        aux_addr  = $urandom;
        aux_wdata = $urandom;
        aux_mask  = 4'($urandom_range(0, 15));
      end
      if (m_busy) dm_ack = ($urandom_range(0, ((c / 500) % 2 == 0) ? 5 : 19) == 0);
      else        dm_ack = ($urandom_range(0, 7) == 0);
      dm_rdata_in = $urandom;
      nxt();
    end

    core_req = 1'b0; aux_req = 1'b0; dm_ack = 1'b0;
    repeat (TO + 4) nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
